// File: rtl/line_mem_arb_pkg.sv
// Shared types and constants for the two-client line memory arbiter.
// States, port ids and the line-width helper live here so the arbiter core and top agree.
package line_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_e;

  localparam int PORT_I    = 0;
  localparam int PORT_D    = 1;
  localparam int NUM_PORTS = 2;

  function automatic int line_bits(input int line_size);
    return line_size * 8;
  endfunction

endpackage

// File: rtl/line_mem_arbiter_rr_arb2.sv
// Two-input grant logic with a pointer that advances on each accepted grant.
// Latency: combinational grant, pointer updates on the cycle after adv.
// Backpressure: none; the caller only strobes adv when the grant is taken. LINE_ARB_DPRIO_EN selects fixed port-1 priority.
module rr_arb2 import line_mem_arb_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       adv,
  output logic       gnt_vld,
  output logic       gnt_id
);

  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    gnt_vld = |req;
`ifdef LINE_ARB_DPRIO_EN
    // D-cache wins every tie; the pointer is frozen at its reset value.
    gnt_id   = req[PORT_D];
    rr_ptr_d = adv ? 1'b0 : rr_ptr_q;
`else
    if (req == 2'b11) begin
      gnt_id = rr_ptr_q;
    end else begin
      gnt_id = req[PORT_D];
    end
    rr_ptr_d = adv ? ~gnt_id : rr_ptr_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/line_mem_arbiter.sv
// Shares one line-granularity DataMemory between I-cache (port 0) and D-cache (port 1), one transaction at a time.
// Latency: grant to mem request 1 cycle; fill data and write-done pass through combinationally.
// Backpressure: c_req_ready pulses only in IDLE; ISSUE holds the request until mem_ready. LINE_ARB_DPRIO_EN = fixed priority.
module line_mem_arbiter import line_mem_arb_pkg::*; #(
  parameter int LINE_SIZE  = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                c_req_valid,
  input  logic [1:0]                c_req_write,
  input  logic [2*ADDR_WIDTH-1:0]   c_req_addr,
  input  logic [2*LINE_SIZE*8-1:0]  c_req_din,
  output logic [1:0]                c_req_ready,
  output logic [1:0]                c_resp_valid,
  output logic [LINE_SIZE*8-1:0]    c_resp_dout,
  output logic                      mem_is_input_valid,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [LINE_SIZE*8-1:0]    mem_din,
  input  logic                      mem_ready,
  input  logic                      mem_is_output_valid,
  input  logic [LINE_SIZE*8-1:0]    mem_dout
);

  localparam int LB = line_bits(LINE_SIZE);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~(ADDR_WIDTH'(LINE_SIZE - 1));

  state_e                state_q, state_d;
  logic                  wr_q, wr_d;
  logic                  gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LB-1:0]         din_q, din_d;

  logic arb_vld, arb_gnt, arb_adv;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (c_req_valid),
    .adv     (arb_adv),
    .gnt_vld (arb_vld),
    .gnt_id  (arb_gnt)
  );

  assign mem_addr = addr_q;
  assign mem_din  = din_q;

  always_comb begin
    state_d            = state_q;
    wr_d               = wr_q;
    gnt_d              = gnt_q;
    addr_d             = addr_q;
    din_d              = din_q;
    arb_adv            = 1'b0;
    c_req_ready        = 2'b00;
    c_resp_valid       = 2'b00;
    c_resp_dout        = '0;
    mem_is_input_valid = 1'b0;
    mem_read           = 1'b0;
    mem_write          = 1'b0;
    // Everything stays quiet while reset is high, so an in-flight job dies silently.
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (arb_vld) begin
            c_req_ready[arb_gnt] = 1'b1;
            arb_adv              = 1'b1;
            wr_d                 = c_req_write[arb_gnt];
            addr_d               = c_req_addr[arb_gnt*ADDR_WIDTH +: ADDR_WIDTH] & ADDR_MASK;
            din_d                = c_req_din[arb_gnt*LB +: LB];
            gnt_d                = arb_gnt;
            state_d              = ISSUE;
          end
        end
        ISSUE: begin
          mem_is_input_valid = 1'b1;
          mem_read           = ~wr_q;
          mem_write          = wr_q;
          if (mem_ready) begin
            if (wr_q) begin
              c_resp_valid[gnt_q] = 1'b1;
              state_d             = IDLE;
            end else begin
              state_d = WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          if (mem_is_output_valid) begin
            c_resp_valid[gnt_q] = 1'b1;
            c_resp_dout         = mem_dout;
            state_d             = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

endmodule

// File: tb/tb_line_mem_arbiter.sv
// Directed bench for line_mem_arbiter: fills, writebacks, arbitration order, reset and spurious responses.
module tb_line_mem_arbiter;
  import line_mem_arb_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   c_req_valid, c_req_write;
  logic [63:0]  c_req_addr;
  logic [255:0] c_req_din;
  logic [1:0]   c_req_ready, c_resp_valid;
  logic [127:0] c_resp_dout;
  logic         mem_is_input_valid, mem_read, mem_write;
  logic [31:0]  mem_addr;
  logic [127:0] mem_din;
  logic         mem_ready, mem_is_output_valid;
  logic [127:0] mem_dout;

  int n_err = 0;
  int n_chk = 0;
  logic [1:0] exp_g [4];

  always #5 clk = ~clk;

  line_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .c_req_valid(c_req_valid), .c_req_write(c_req_write),
    .c_req_addr(c_req_addr), .c_req_din(c_req_din),
    .c_req_ready(c_req_ready), .c_resp_valid(c_resp_valid), .c_resp_dout(c_resp_dout),
    .mem_is_input_valid(mem_is_input_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_ready(mem_ready), .mem_is_output_valid(mem_is_output_valid), .mem_dout(mem_dout)
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    c_req_valid = 2'b00; c_req_write = 2'b00;
    c_req_addr = '0; c_req_din = '0;
    mem_ready = 1'b0; mem_is_output_valid = 1'b0; mem_dout = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_in();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
`ifdef LINE_ARB_DPRIO_EN
    exp_g[0] = 2'b10; exp_g[1] = 2'b10; exp_g[2] = 2'b10; exp_g[3] = 2'b10;
`else
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`endif
    reset = 1'b1;
    clear_in();
    cyc();
    cyc();
    // Reset state, with requests and a response pending that must be ignored.
    c_req_valid = 2'b11; mem_is_output_valid = 1'b1;
    #1;
    chk("rst_ready", c_req_ready, 2'b00);
    chk("rst_resp", c_resp_valid, 2'b00);
    chk("rst_memvld", mem_is_input_valid, 1'b0);
    chk("rst_rdwr", {mem_read, mem_write}, 2'b00);
    chk("rst_state", dut.state_q, IDLE);
    clear_in();
    cyc();
    reset = 1'b0;

    // Test 1: single fill on port 0.
    cyc();
    c_req_valid = 2'b01; c_req_addr[31:0] = 32'h1234;
    #1 chk("t1_ready_T0", c_req_ready, 2'b01);
    cyc();
    c_req_valid = 2'b00; mem_ready = 1'b1;
    #1;
    chk("t1_memvld_T1", mem_is_input_valid, 1'b1);
    chk("t1_read_T1", {mem_read, mem_write}, 2'b10);
    chk("t1_addr_T1", mem_addr, 32'h1230);
    cyc();
    mem_ready = 1'b0;
    #1;
    chk("t1_memvld_T2", mem_is_input_valid, 1'b0);
    chk("t1_resp_T2", c_resp_valid, 2'b00);
    cyc();
    #1 chk("t1_resp_T3", c_resp_valid, 2'b00);
    cyc();
    mem_is_output_valid = 1'b1; mem_dout = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    #1;
    chk("t1_resp_T4", c_resp_valid, 2'b01);
    chk("t1_dout_T4", c_resp_dout, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
    cyc();
    mem_is_output_valid = 1'b0;
    #1;
    chk("t1_resp_T5", c_resp_valid, 2'b00);
    chk("t1_state_T5", dut.state_q, IDLE);

    // Test 2: both ports requesting continuously from reset.
    do_reset();
    c_req_valid = 2'b11; c_req_write = 2'b11; mem_ready = 1'b1;
    c_req_addr = {32'h2011, 32'h100F};
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("t2_grant%0d", k), c_req_ready, exp_g[k]);
      cyc();
      #1;
      chk($sformatf("t2_done%0d", k), c_resp_valid, exp_g[k]);
      chk($sformatf("t2_addr%0d", k), mem_addr, (exp_g[k] == 2'b01) ? 32'h1000 : 32'h2010);
      cyc();
    end
    clear_in();

    // Test 3: port-1 writeback stalled by mem_ready low for 5 cycles.
    c_req_valid = 2'b10; c_req_write = 2'b10; c_req_addr[63:32] = 32'hABCD;
    c_req_din[255:128] = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    #1 chk("t3_ready", c_req_ready, 2'b10);
    cyc();
    c_req_valid = 2'b00; c_req_din = '1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("t3_hold_vld%0d", k), {mem_is_input_valid, mem_write, mem_read}, 3'b110);
      chk($sformatf("t3_hold_din%0d", k), mem_din, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555);
      chk($sformatf("t3_hold_resp%0d", k), c_resp_valid, 2'b00);
      cyc();
    end
    mem_ready = 1'b1;
    #1;
    chk("t3_accept_resp", c_resp_valid, 2'b10);
    chk("t3_accept_addr", mem_addr, 32'hABC0);
    cyc();
    mem_ready = 1'b0;
    #1 chk("t3_idle_memvld", mem_is_input_valid, 1'b0);

    // Test 4: port 0 waits while port 1's fill is outstanding.
    c_req_valid = 2'b10; c_req_write = 2'b00; c_req_addr = {32'h4000, 32'h5000};
    #1 chk("t4_ready_p1", c_req_ready, 2'b10);
    cyc();
    c_req_valid = 2'b00; mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0; c_req_valid = 2'b01;
    #1 chk("t4_block_T2", c_req_ready, 2'b00);
    cyc();
    #1 chk("t4_block_T3", c_req_ready, 2'b00);
    cyc();
    mem_is_output_valid = 1'b1; mem_dout = 128'h55AA;
    #1;
    chk("t4_p1_resp", c_resp_valid, 2'b10);
    chk("t4_p1_dout", c_resp_dout, 128'h55AA);
    chk("t4_block_T4", c_req_ready, 2'b00);
    cyc();
    mem_is_output_valid = 1'b0;
    #1 chk("t4_p0_grant", c_req_ready, 2'b01);
    cyc();
    c_req_valid = 2'b00; mem_ready = 1'b1;
    #1 chk("t4_p0_addr", mem_addr, 32'h5000);
    cyc();
    mem_ready = 1'b0;
    cyc();
    mem_is_output_valid = 1'b1; mem_dout = 128'h77;
    #1 chk("t4_p0_resp", c_resp_valid, 2'b01);
    cyc();
    clear_in();

    // Test 5: reset during WAIT_RD drops the fill.
    c_req_valid = 2'b01; c_req_addr = 64'h0000_0000_0000_0040;
    cyc();
    c_req_valid = 2'b00; mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    #1 chk("t5_state_wait", dut.state_q, WAIT_RD);
    cyc();
    reset = 1'b1; mem_is_output_valid = 1'b1; mem_dout = 128'h99;
    #1 chk("t5_resp_in_rst", c_resp_valid, 2'b00);
    cyc();
    reset = 1'b0;
    #1;
    chk("t5_resp_after", c_resp_valid, 2'b00);
    chk("t5_state", dut.state_q, IDLE);
    chk("t5_rr_ptr", dut.u_arb.rr_ptr_q, 1'b0);
    cyc();
    mem_is_output_valid = 1'b0;

    // Test 6: spurious memory response while idle.
    mem_is_output_valid = 1'b1; mem_dout = 128'h1;
    #1 chk("t6_resp", c_resp_valid, 2'b00);
    cyc();
    mem_is_output_valid = 1'b0;
    #1;
    chk("t6_state", dut.state_q, IDLE);
    chk("t6_memvld", mem_is_input_valid, 1'b0);
    c_req_valid = 2'b11;
    #1 chk("t6_tie_grant", c_req_ready, exp_g[0]);
    cyc();
    clear_in();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
